// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer: serialises the trap CSR updates (MEPC, MCAUSE,
// MTVAL, MSTATUS) or the MRET MSTATUS restore, then issues a single fetch redirect.
module trap_sequencer #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic        trap_is_irq,
  input  logic [3:0]  trap_code,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        trap_ack,
  output logic        mret_ack,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  input  logic        csr_wdone,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        pipe_flush
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STATUS,
    S_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic        is_mret_q;
  logic        is_irq_q;
  logic [3:0]  code_q;
  logic [31:0] pc_q;
  logic [31:0] tval_q;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;

  logic        trap_accept;
  logic        mret_accept;
  logic [31:0] status_trap;
  logic [31:0] status_mret;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  assign trap_accept = (state_q == S_IDLE) && trap_req;
  assign mret_accept = (state_q == S_IDLE) && !trap_req && mret_req;

  always_comb begin
    status_trap        = mstatus_q;
    status_trap[7]     = mstatus_q[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;
    status_mret        = mstatus_q;
    status_mret[3]     = mstatus_q[7];
    status_mret[7]     = 1'b1;
    status_mret[12:11] = 2'b11;
  end

  // Vectored offset only for interrupts in MODE=1; MODE 2/3 fall back to direct.
  assign trap_base = {mtvec_q[31:2], 2'b00};
  always_comb begin
    trap_target = trap_base;
    if (VECTORED_EN && (mtvec_q[1:0] == 2'b01) && is_irq_q)
      trap_target = trap_base + {26'b0, code_q, 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      first_q   <= 1'b0;
      is_mret_q <= 1'b0;
      is_irq_q  <= 1'b0;
      code_q    <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      if (trap_accept || mret_accept) begin
        is_mret_q <= mret_accept;
        is_irq_q  <= trap_is_irq;
        code_q    <= trap_code;
        pc_q      <= trap_pc;
        tval_q    <= trap_tval;
        mstatus_q <= mstatus_in;
        mtvec_q   <= mtvec_in;
        mepc_q    <= mepc_in;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    first_d        = 1'b0;
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    busy           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pipe_flush     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Acks are gated by rst so that a held request cannot pulse them during reset.
        if (trap_accept && !rst) begin
          trap_ack = 1'b1;
          state_d  = S_W_EPC;
          first_d  = 1'b1;
        end else if (mret_accept && !rst) begin
          mret_ack = 1'b1;
          state_d  = S_W_STATUS;
          first_d  = 1'b1;
        end
      end
      S_W_EPC: begin
        busy      = 1'b1;
        csr_we    = first_q;
        csr_waddr = ADDR_MEPC;
        csr_wdata = {pc_q[31:2], 2'b00};
        if (csr_wdone) begin
          state_d = S_W_CAUSE;
          first_d = 1'b1;
        end
      end
      S_W_CAUSE: begin
        busy      = 1'b1;
        csr_we    = first_q;
        csr_waddr = ADDR_MCAUSE;
        csr_wdata = {is_irq_q, 27'b0, code_q};
        if (csr_wdone) begin
          state_d = S_W_TVAL;
          first_d = 1'b1;
        end
      end
      S_W_TVAL: begin
        busy      = 1'b1;
        csr_we    = first_q;
        csr_waddr = ADDR_MTVAL;
        csr_wdata = is_irq_q ? 32'h0 : tval_q;
        if (csr_wdone) begin
          state_d = S_W_STATUS;
          first_d = 1'b1;
        end
      end
      S_W_STATUS: begin
        busy      = 1'b1;
        csr_we    = first_q;
        csr_waddr = ADDR_MSTATUS;
        csr_wdata = is_mret_q ? status_mret : status_trap;
        if (csr_wdone)
          state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        busy           = 1'b1;
        redirect_valid = 1'b1;
        pipe_flush     = 1'b1;
        redirect_pc    = is_mret_q ? {mepc_q[31:2], 2'b00} : trap_target;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap, interrupt (vectored and direct builds),
// MRET, request collision with slow write completion, and mid-sequence reset.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, trap_is_irq, mret_req, csr_wdone;
  logic [3:0]  trap_code;
  logic [31:0] trap_pc, trap_tval, mstatus_in, mtvec_in, mepc_in;

  logic        trap_ack, mret_ack, csr_we, busy, redirect_valid, pipe_flush;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  logic        d_trap_ack, d_mret_ack, d_csr_we, d_busy, d_redirect_valid, d_pipe_flush;
  logic [11:0] d_csr_waddr;
  logic [31:0] d_csr_wdata, d_redirect_pc;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_is_irq(trap_is_irq),
    .trap_code(trap_code), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .trap_ack(trap_ack), .mret_ack(mret_ack), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wdone(csr_wdone), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pipe_flush(pipe_flush)
  );

  trap_sequencer #(.VECTORED_EN(1'b0)) dut_direct (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_is_irq(trap_is_irq),
    .trap_code(trap_code), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .trap_ack(d_trap_ack), .mret_ack(d_mret_ack), .csr_we(d_csr_we),
    .csr_waddr(d_csr_waddr), .csr_wdata(d_csr_wdata), .csr_wdone(csr_wdone), .busy(d_busy),
    .redirect_valid(d_redirect_valid), .redirect_pc(d_redirect_pc), .pipe_flush(d_pipe_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called right after cyc() on the first cycle of a write state.
  task automatic do_write(input string tag, input logic [11:0] addr,
                          input logic [31:0] data, input int extra_wait);
    #1;
    chk({tag, " we"}, {31'b0, csr_we}, 32'd1);
    chk({tag, " addr"}, {20'b0, csr_waddr}, {20'b0, addr});
    chk({tag, " data"}, csr_wdata, data);
    chk({tag, " busy"}, {31'b0, busy}, 32'd1);
    $display("write %s: addr=%03h data=%08h", tag, csr_waddr, csr_wdata);
    cyc();
    for (int i = 0; i < extra_wait; i++) begin
      chk({tag, " we held low"}, {31'b0, csr_we}, 32'd0);
      chk({tag, " addr held"}, {20'b0, csr_waddr}, {20'b0, addr});
      chk({tag, " data held"}, csr_wdata, data);
      cyc();
    end
    csr_wdone = 1'b1;
    #1;
    chk({tag, " we on wdone"}, {31'b0, csr_we}, 32'd0);
    chk({tag, " addr on wdone"}, {20'b0, csr_waddr}, {20'b0, addr});
    cyc();
    csr_wdone = 1'b0;
  endtask

  task automatic chk_redirect(input string tag, input logic [31:0] pc);
    #1;
    chk({tag, " redirect_valid"}, {31'b0, redirect_valid}, 32'd1);
    chk({tag, " pipe_flush"}, {31'b0, pipe_flush}, 32'd1);
    chk({tag, " redirect_pc"}, redirect_pc, pc);
    chk({tag, " we in redirect"}, {31'b0, csr_we}, 32'd0);
    $display("redirect %s: pc=%08h", tag, redirect_pc);
    cyc();
    chk({tag, " redirect ends"}, {31'b0, redirect_valid}, 32'd0);
    chk({tag, " flush ends"}, {31'b0, pipe_flush}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; trap_req = 1'b1; trap_is_irq = 1'b0; mret_req = 1'b0; csr_wdone = 1'b0;
    trap_code = '0; trap_pc = '0; trap_tval = '0;
    mstatus_in = '0; mtvec_in = '0; mepc_in = '0;
    #2;
    chk("reset trap_ack", {31'b0, trap_ack}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset we", {31'b0, csr_we}, 32'd0);
    chk("reset redirect", {31'b0, redirect_valid}, 32'd0);
    trap_req = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Stray wdone while idle must be ignored
    csr_wdone = 1'b1;
    cyc();
    csr_wdone = 1'b0;
    #1;
    chk("stray wdone busy", {31'b0, busy}, 32'd0);
    chk("stray wdone we", {31'b0, csr_we}, 32'd0);
    cyc();

    // 1: exception, inputs changed after accept to prove latching
    trap_req = 1'b1; trap_is_irq = 1'b0; trap_code = 4'd2; trap_pc = 32'h100;
    trap_tval = 32'hDEAD; mtvec_in = 32'h8000_0001; mstatus_in = 32'h8;
    #1;
    chk("t1 trap_ack", {31'b0, trap_ack}, 32'd1);
    chk("t1 busy at accept", {31'b0, busy}, 32'd0);
    $display("accept t1 exception code=2");
    cyc();
    trap_req = 1'b0; mtvec_in = 32'hFFFF_FFFF; mstatus_in = 32'h0; trap_tval = 32'h0;
    trap_pc = 32'h0;
    do_write("t1 mepc", 12'h341, 32'h0000_0100, 0);
    do_write("t1 mcause", 12'h342, 32'h0000_0002, 0);
    do_write("t1 mtval", 12'h343, 32'h0000_DEAD, 0);
    do_write("t1 mstatus", 12'h300, 32'h0000_1880, 0);
    chk_redirect("t1", 32'h8000_0000);
    chk("t1 idle after", {31'b0, busy}, 32'd0);
    cyc();

    // 2: interrupt, vectored vs direct builds
    trap_req = 1'b1; trap_is_irq = 1'b1; trap_code = 4'd7; trap_pc = 32'h207;
    trap_tval = 32'h1234_5678; mtvec_in = 32'h8000_0001; mstatus_in = 32'h0;
    #1;
    chk("t2 trap_ack", {31'b0, trap_ack}, 32'd1);
    cyc();
    trap_req = 1'b0;
    do_write("t2 mepc", 12'h341, 32'h0000_0204, 0);
    do_write("t2 mcause", 12'h342, 32'h8000_0007, 0);
    do_write("t2 mtval", 12'h343, 32'h0000_0000, 0);
    #1;
    chk("t2 direct data", d_csr_wdata, 32'h0000_1800);
    do_write("t2 mstatus", 12'h300, 32'h0000_1800, 0);
    #1;
    chk("t2 direct redirect_pc", d_redirect_pc, 32'h8000_0000);
    chk_redirect("t2", 32'h8000_001C);
    cyc();

    // 3: MRET
    mret_req = 1'b1; mstatus_in = 32'h1880; mepc_in = 32'h204;
    #1;
    chk("t3 mret_ack", {31'b0, mret_ack}, 32'd1);
    chk("t3 trap_ack", {31'b0, trap_ack}, 32'd0);
    cyc();
    mret_req = 1'b0; mepc_in = 32'h0; mstatus_in = 32'h0;
    do_write("t3 mstatus", 12'h300, 32'h0000_1888, 0);
    chk_redirect("t3", 32'h0000_0204);
    cyc();

    // 4: collision; MRET held through trap, slow wdone on mcause
    trap_req = 1'b1; mret_req = 1'b1; trap_is_irq = 1'b0; trap_code = 4'd11;
    trap_pc = 32'h3000; trap_tval = 32'h0; mtvec_in = 32'h0000_1000; mstatus_in = 32'h0;
    mepc_in = 32'h0000_0404;
    #1;
    chk("t4 trap_ack", {31'b0, trap_ack}, 32'd1);
    chk("t4 no mret_ack", {31'b0, mret_ack}, 32'd0);
    cyc();
    trap_req = 1'b0; mstatus_in = 32'h80;
    do_write("t4 mepc", 12'h341, 32'h0000_3000, 0);
    chk("t4 mret waits", {31'b0, mret_ack}, 32'd0);
    do_write("t4 mcause", 12'h342, 32'h0000_000B, 3);
    do_write("t4 mtval", 12'h343, 32'h0000_0000, 0);
    do_write("t4 mstatus", 12'h300, 32'h0000_1800, 0);
    chk_redirect("t4", 32'h0000_1000);
    chk("t4 mret_ack after", {31'b0, mret_ack}, 32'd1);
    cyc();
    mret_req = 1'b0;
    do_write("t4 mret mstatus", 12'h300, 32'h0000_1888, 0);
    chk_redirect("t4 mret", 32'h0000_0404);
    cyc();

    // 5: reset during W_TVAL, then clean trap
    trap_req = 1'b1; trap_is_irq = 1'b0; trap_code = 4'd4; trap_pc = 32'h500;
    trap_tval = 32'hBEEF; mtvec_in = 32'h0000_2001; mstatus_in = 32'h8;
    cyc();
    trap_req = 1'b0;
    do_write("t5 mepc", 12'h341, 32'h0000_0500, 0);
    do_write("t5 mcause", 12'h342, 32'h0000_0004, 0);
    #1;
    chk("t5 in W_TVAL", {20'b0, csr_waddr}, 32'h343);
    rst = 1'b1;
    #1;
    chk("t5 rst we", {31'b0, csr_we}, 32'd0);
    chk("t5 rst busy", {31'b0, busy}, 32'd0);
    chk("t5 rst addr", {20'b0, csr_waddr}, 32'd0);
    chk("t5 rst data", csr_wdata, 32'd0);
    $display("reset asserted mid-sequence");
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5 no redirect", {31'b0, redirect_valid}, 32'd0);
      chk("t5 idle", {31'b0, busy}, 32'd0);
    end
    trap_req = 1'b1; trap_code = 4'd5; trap_pc = 32'h2003; trap_tval = 32'h77;
    mstatus_in = 32'h0; mtvec_in = 32'h0000_0401;
    #1;
    chk("t5 retrap ack", {31'b0, trap_ack}, 32'd1);
    cyc();
    trap_req = 1'b0;
    do_write("t5 mepc2", 12'h341, 32'h0000_2000, 0);
    do_write("t5 mcause2", 12'h342, 32'h0000_0005, 0);
    do_write("t5 mtval2", 12'h343, 32'h0000_0077, 0);
    do_write("t5 mstatus2", 12'h300, 32'h0000_1800, 0);
    chk_redirect("t5", 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
